// File: rtl/turf_bus_arbiter.sv
// Two-port round-robin arbiter for the TURF register bus: one latched request per port,
// one TURF access in flight at a time. Optional WAIT timeout: define TURF_ARB_TIMEOUT_EN.
module turf_bus_arbiter #(
    parameter int                    ADDR_WIDTH     = 6,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERROR_WORD     = DATA_WIDTH'(32'hDEADBEEF)
) (
    input  logic                  clk_i,
    input  logic                  nrst_i,
    input  logic                  p0_wr_i,
    input  logic                  p0_rd_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [DATA_WIDTH-1:0] p0_dat_i,
    output logic [DATA_WIDTH-1:0] p0_dat_o,
    output logic                  p0_ack_o,
    input  logic                  p1_wr_i,
    input  logic                  p1_rd_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [DATA_WIDTH-1:0] p1_dat_i,
    output logic [DATA_WIDTH-1:0] p1_dat_o,
    output logic                  p1_ack_o,
    output logic                  turf_wr_o,
    output logic                  turf_rd_o,
    output logic [ADDR_WIDTH-1:0] turf_addr_o,
    output logic [DATA_WIDTH-1:0] turf_dat_o,
    input  logic [DATA_WIDTH-1:0] turf_dat_i,
    input  logic                  turf_ack_i,
    output logic                  grant_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    input  logic                  timeout_clr_i
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                state_q;
    logic [1:0]            strobe_wr;
    logic [1:0]            strobe_rd;
    logic [ADDR_WIDTH-1:0] req_addr [2];
    logic [DATA_WIDTH-1:0] req_dat  [2];

    logic [1:0]            pend_q;
    logic [1:0]            pend_wr_q;
    logic [ADDR_WIDTH-1:0] pend_addr_q [2];
    logic [DATA_WIDTH-1:0] pend_dat_q  [2];

    logic                  grant_q;
    logic                  turf_wr_q;
    logic                  turf_rd_q;
    logic [ADDR_WIDTH-1:0] turf_addr_q;
    logic [DATA_WIDTH-1:0] turf_dat_q;

    logic                  ack_hit;
    logic                  to_hit;
    logic                  done;
    logic                  sel;
    logic [DATA_WIDTH-1:0] resp_dat;

    assign strobe_wr   = {p1_wr_i, p0_wr_i};
    assign strobe_rd   = {p1_rd_i, p0_rd_i};
    assign req_addr[0] = p0_addr_i;
    assign req_addr[1] = p1_addr_i;
    assign req_dat[0]  = p0_dat_i;
    assign req_dat[1]  = p1_dat_i;

    assign ack_hit = (state_q == S_WAIT) && turf_ack_i;

`ifdef TURF_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    // A real ack arriving on the last counted cycle takes priority over the timeout.
    assign to_hit    = (state_q == S_WAIT) && !turf_ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_o = timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{timeout_clr_i, TIMEOUT_CYCLES};
    assign to_hit     = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    assign done     = ack_hit || to_hit;
    assign resp_dat = to_hit ? ERROR_WORD : turf_dat_i;
    assign p0_ack_o = done && !grant_q;
    assign p1_ack_o = done && grant_q;
    assign p0_dat_o = p0_ack_o ? resp_dat : '0;
    assign p1_dat_o = p1_ack_o ? resp_dat : '0;

    // Round-robin only matters when both ports wait; otherwise take whichever is pending.
    assign sel = (pend_q == 2'b11) ? ~grant_q : pend_q[1];

    assign turf_wr_o   = turf_wr_q;
    assign turf_rd_o   = turf_rd_q;
    assign turf_addr_o = turf_addr_q;
    assign turf_dat_o  = turf_dat_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != S_IDLE);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            pend_q    <= '0;
            pend_wr_q <= '0;
            for (int i = 0; i < 2; i++) begin
                pend_addr_q[i] <= '0;
                pend_dat_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (done && (grant_q == 1'(i))) begin
                    pend_q[i] <= 1'b0;
                end else if (!pend_q[i] && (strobe_wr[i] || strobe_rd[i])) begin
                    pend_q[i]      <= 1'b1;
                    pend_wr_q[i]   <= strobe_wr[i];
                    pend_addr_q[i] <= req_addr[i];
                    pend_dat_q[i]  <= req_dat[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q     <= S_IDLE;
            grant_q     <= 1'b1;
            turf_wr_q   <= 1'b0;
            turf_rd_q   <= 1'b0;
            turf_addr_q <= '0;
            turf_dat_q  <= '0;
`ifdef TURF_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|pend_q) begin
                        grant_q     <= sel;
                        turf_addr_q <= pend_addr_q[sel];
                        turf_dat_q  <= pend_dat_q[sel];
                        turf_wr_q   <= pend_wr_q[sel];
                        turf_rd_q   <= ~pend_wr_q[sel];
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    turf_wr_q <= 1'b0;
                    turf_rd_q <= 1'b0;
                    state_q   <= S_WAIT;
`ifdef TURF_ARB_TIMEOUT_EN
                    cnt_q     <= '0;
`endif
                end
                S_WAIT: begin
                    if (done) begin
                        state_q <= S_IDLE;
                    end
`ifdef TURF_ARB_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
`ifdef TURF_ARB_TIMEOUT_EN
            if (to_hit) begin
                timeout_q <= 1'b1;
            end else if (timeout_clr_i) begin
                timeout_q <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_turf_bus_arbiter.sv
// Randomized bench for turf_bus_arbiter: a driver issues port requests and plays the TURF
// slave, a negedge monitor checks every cycle against a queue-based arbitration model.
module tb_turf_bus_arbiter;

    localparam int          AW = 6;
    localparam int          DW = 32;
    localparam int          TO = 16;
    localparam logic [31:0] EW = 32'hDEADBEEF;
`ifdef TURF_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          nrst_i;
    logic          p0_wr_i, p0_rd_i, p1_wr_i, p1_rd_i;
    logic [AW-1:0] p0_addr_i, p1_addr_i;
    logic [DW-1:0] p0_dat_i, p1_dat_i;
    logic [DW-1:0] p0_dat_o, p1_dat_o;
    logic          p0_ack_o, p1_ack_o;
    logic          turf_wr_o, turf_rd_o;
    logic [AW-1:0] turf_addr_o;
    logic [DW-1:0] turf_dat_o;
    logic [DW-1:0] turf_dat_i;
    logic          turf_ack_i;
    logic          grant_o, busy_o, timeout_o, timeout_clr_i;

    turf_bus_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO),
        .ERROR_WORD    (EW)
    ) dut (
        .clk_i(clk_i), .nrst_i(nrst_i),
        .p0_wr_i(p0_wr_i), .p0_rd_i(p0_rd_i), .p0_addr_i(p0_addr_i), .p0_dat_i(p0_dat_i),
        .p0_dat_o(p0_dat_o), .p0_ack_o(p0_ack_o),
        .p1_wr_i(p1_wr_i), .p1_rd_i(p1_rd_i), .p1_addr_i(p1_addr_i), .p1_dat_i(p1_dat_i),
        .p1_dat_o(p1_dat_o), .p1_ack_o(p1_ack_o),
        .turf_wr_o(turf_wr_o), .turf_rd_o(turf_rd_o), .turf_addr_o(turf_addr_o),
        .turf_dat_o(turf_dat_o), .turf_dat_i(turf_dat_i), .turf_ack_i(turf_ack_i),
        .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o), .timeout_clr_i(timeout_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int            port;
        int            cyc;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } req_t;

    // Accepted but not yet issued requests (pushed by the driver, consumed by the monitor).
    req_t req_q[$];

    // Driver-owned state
    bit          outst[2];
    bit          rel[2];
    int          exp_ack_port = -1;
    logic [31:0] exp_ack_dat  = '0;
    bit          exp_to_ev    = 1'b0;
    bit          waiting      = 1'b0;
    int          cnt, elapsed, wport;
    int          last_seq     = 0;
    bit          reached_mid  = 1'b0;
    bit          final_req    = 1'b0;

    // Monitor-owned state
    int          issue_seq    = 0;
    int          cur_port_m   = 0;
    int          ack_delay_m  = 0;
    bit          inflight_m   = 1'b0;
    int          next_free    = 0;
    bit          last_grant_m = 1'b1;
    bit          to_flag_m    = 1'b0;
    bit          final_done   = 1'b0;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_dat;
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            if (!nrst_i) begin
                req_q.delete();
                inflight_m   = 1'b0;
                next_free    = 0;
                last_grant_m = 1'b1;
                to_flag_m    = 1'b0;
                chk("rst_turf_wr", turf_wr_o, 0);
                chk("rst_turf_rd", turf_rd_o, 0);
                chk("rst_p0_ack", p0_ack_o, 0);
                chk("rst_p1_ack", p1_ack_o, 0);
                chk("rst_grant", grant_o, 1);
                chk("rst_busy", busy_o, 0);
                chk("rst_addr", turf_addr_o, 0);
                chk("rst_dat", turf_dat_o, 0);
                chk("rst_timeout", timeout_o, 0);
            end else begin
                bit el[2];
                bit exp_st;
                el[0] = 1'b0;
                el[1] = 1'b0;
                // A request strobed in cycle T is visible to arbitration at T+1 and issued at T+2.
                foreach (req_q[i]) if (req_q[i].cyc <= cyc - 2) el[req_q[i].port] = 1'b1;
                exp_st = !inflight_m && (cyc >= next_free) && (el[0] || el[1]);
                chk("turf_strobe", turf_wr_o | turf_rd_o, exp_st);
                if (exp_st) begin
                    int g;
                    int idx;
                    req_t r;
                    g = (el[0] && el[1]) ? int'(!last_grant_m) : (el[1] ? 1 : 0);
                    idx = 0;
                    foreach (req_q[i]) if (req_q[i].port == g) idx = i;
                    r = req_q[idx];
                    req_q.delete(idx);
                    chk("issue_grant", grant_o, g);
                    chk("issue_wr", turf_wr_o, r.wr);
                    chk("issue_rd", turf_rd_o, !r.wr);
                    chk("issue_addr", turf_addr_o, r.addr);
                    chk("issue_dat", turf_dat_o, r.dat);
                    inflight_m   = 1'b1;
                    cur_port_m   = g;
                    cur_addr     = r.addr;
                    cur_dat      = r.dat;
                    last_grant_m = g[0];
                    ack_delay_m  = ($urandom_range(0, 7) == 0) ?
                                   ($urandom_range(0, 1) == 1 ? 15 : 22) : int'($urandom_range(0, 3));
                    issue_seq++;
                end else if (inflight_m) begin
                    chk("hold_addr", turf_addr_o, cur_addr);
                    chk("hold_dat", turf_dat_o, cur_dat);
                    chk("hold_grant", grant_o, cur_port_m);
                end
                chk("busy", busy_o, inflight_m);
                for (int p = 0; p < 2; p++) begin
                    bit e;
                    e = (exp_ack_port == p);
                    chk(p == 0 ? "p0_ack" : "p1_ack", p == 0 ? p0_ack_o : p1_ack_o, e);
                    chk(p == 0 ? "p0_dat" : "p1_dat", p == 0 ? p0_dat_o : p1_dat_o,
                        e ? exp_ack_dat : 32'h0);
                end
                if (exp_ack_port >= 0) begin
                    inflight_m = 1'b0;
                    next_free  = cyc + 2;
                end
                chk("timeout_flag", timeout_o, to_flag_m);
                if (exp_to_ev) to_flag_m = 1'b1;
                else if (timeout_clr_i) to_flag_m = 1'b0;
                if (final_req && !final_done) begin
                    final_done = 1'b1;
                    chk("drain_queue", req_q.size(), 0);
                    chk("drain_idle", inflight_m, 0);
                    chk("reset_mid_wait_reached", reached_mid, 1);
                end
            end
        end
    end

    // ---------------- driver / TURF responder ----------------
    task automatic drive_cycle(input int pct, input bit force_both);
        @(posedge clk_i);
        #1;
        for (int p = 0; p < 2; p++) if (rel[p]) begin outst[p] = 1'b0; rel[p] = 1'b0; end
        turf_ack_i    = 1'b0;
        turf_dat_i    = $urandom;
        exp_ack_port  = -1;
        exp_ack_dat   = '0;
        exp_to_ev     = 1'b0;
        timeout_clr_i = ($urandom_range(0, 11) == 0);
        p0_wr_i = 1'b0; p0_rd_i = 1'b0; p1_wr_i = 1'b0; p1_rd_i = 1'b0;
        if (issue_seq != last_seq) begin
            last_seq = issue_seq;
            waiting  = 1'b1;
            cnt      = ack_delay_m;
            elapsed  = 0;
            wport    = cur_port_m;
        end
        if (waiting) begin
            if (cnt == 0) begin
                turf_ack_i   = 1'b1;
                exp_ack_port = wport;
                exp_ack_dat  = turf_dat_i;
                waiting      = 1'b0;
                rel[wport]   = 1'b1;
            end else if (TO_EN && elapsed == TO - 1) begin
                exp_ack_port = wport;
                exp_ack_dat  = EW;
                exp_to_ev    = 1'b1;
                waiting      = 1'b0;
                rel[wport]   = 1'b1;
            end else begin
                cnt--;
                elapsed++;
            end
        end else if ($urandom_range(0, 7) == 0) begin
            turf_ack_i = 1'b1;   // stray ack outside WAIT must be ignored
        end
        for (int p = 0; p < 2; p++) begin
            if (force_both || ($urandom_range(0, 99) < pct)) begin
                int   mode;
                req_t r;
                mode   = force_both ? 1 : int'($urandom_range(0, 2));
                r.port = p;
                r.cyc  = cyc;
                r.wr   = (mode != 1);
                r.addr = AW'($urandom);
                r.dat  = $urandom;
                if (p == 0) begin
                    p0_wr_i = (mode != 1); p0_rd_i = (mode != 0);
                    p0_addr_i = r.addr; p0_dat_i = r.dat;
                end else begin
                    p1_wr_i = (mode != 1); p1_rd_i = (mode != 0);
                    p1_addr_i = r.addr; p1_dat_i = r.dat;
                end
                if (!outst[p]) begin
                    outst[p] = 1'b1;
                    req_q.push_back(r);
                end
            end
        end
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk_i);
        #1;
        p0_wr_i = 1'b0; p0_rd_i = 1'b0; p1_wr_i = 1'b0; p1_rd_i = 1'b0;
        turf_ack_i    = 1'b0;
        timeout_clr_i = 1'b0;
        exp_ack_port  = -1;
        exp_to_ev     = 1'b0;
        nrst_i        = 1'b0;
        waiting       = 1'b0;
        for (int p = 0; p < 2; p++) begin outst[p] = 1'b0; rel[p] = 1'b0; end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            #1;
            turf_ack_i = (i == 0);
        end
        @(posedge clk_i);
        #1;
        nrst_i     = 1'b1;
        turf_ack_i = 1'b1;   // late ack from the aborted access lands in IDLE
        last_seq   = issue_seq;
    endtask

    initial begin
        int guard;
        nrst_i = 1'b0;
        p0_wr_i = 1'b0; p0_rd_i = 1'b0; p0_addr_i = '0; p0_dat_i = '0;
        p1_wr_i = 1'b0; p1_rd_i = 1'b0; p1_addr_i = '0; p1_dat_i = '0;
        turf_ack_i = 1'b0; turf_dat_i = '0; timeout_clr_i = 1'b0;
        for (int p = 0; p < 2; p++) begin outst[p] = 1'b0; rel[p] = 1'b0; end
        repeat (3) @(posedge clk_i);
        #1;
        nrst_i = 1'b1;

        drive_cycle(0, 1'b1);              // simultaneous reads: port 0 must win first
        repeat (300) drive_cycle(30, 1'b0);
        repeat (150) drive_cycle(100, 1'b0);   // saturated: grants must alternate

        guard = 0;
        do begin
            drive_cycle(30, 1'b0);
            guard++;
        end while (!(waiting && cnt > 0) && guard < 300);
        reached_mid = waiting;
        do_reset(2);

        repeat (300) drive_cycle(40, 1'b0);
        repeat (80) drive_cycle(0, 1'b0);
        final_req = 1'b1;
        drive_cycle(0, 1'b0);
        drive_cycle(0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
